// File: rtl/bingo_pkg.sv
// Shared constants, FSM state type and line-mask table for the bingo board
// engine. Cell i sits at x = i % N, y = i / N.
package bingo_pkg;
  localparam int N         = 5;
  localparam int NUM_W     = 5;
  localparam int CELLS     = N * N;
  localparam int LINES     = 2 * N + 2;
  localparam int WIN_LINES = 5;
  localparam int IDX_W     = 5;
  localparam int J_W       = 4;

  localparam logic [NUM_W-1:0] MAX_NUM  = NUM_W'(CELLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
  localparam logic [J_W-1:0]   LAST_J   = J_W'(LINES - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, COUNT, DONE} state_e;

  // Entry j: [4:0] rows y=0..4, [9:5] columns x=0..4, [10] diagonal,
  // [11] anti-diagonal. Listed MSB (j=11) first.
  localparam logic [LINES-1:0][CELLS-1:0] LINE_MASKS = {
    25'h0111110, 25'h1041041,
    25'h1084210, 25'h0842108, 25'h0421084, 25'h0210842, 25'h0108421,
    25'h1F00000, 25'h00F8000, 25'h0007C00, 25'h00003E0, 25'h000001F
  };

  // {tens, ones} of a 0..12 count.
  function automatic logic [7:0] to_bcd(input logic [3:0] c);
    if (c >= 4'd10) return {4'd1, c - 4'd10};
    else            return {4'd0, c};
  endfunction
endpackage

// File: rtl/bingo_mark_ctrl_if.sv
// Call handshake bundle: request (call_valid/call_num), ready, and the
// one-cycle completion pulse with its outcome flags.
// master = caller, slave = bingo_mark_ctrl.
interface bingo_mark_ctrl_if;
  import bingo_pkg::*;
  logic             call_valid;
  logic [NUM_W-1:0] call_num;
  logic             call_ready;
  logic             done;
  logic             hit;
  logic             dup;
  logic             miss;

  modport master (output call_valid, call_num,
                  input  call_ready, done, hit, dup, miss);
  modport slave  (input  call_valid, call_num,
                  output call_ready, done, hit, dup, miss);
endinterface

// File: rtl/bingo_line_mask.sv
// Combinational lookup of the 25-bit cell mask for bingo line j.
// Ports: j (line index 0..11), mask (cells on that line; 0 for j > 11).
module bingo_line_mask
  import bingo_pkg::*;
(
  input  logic [J_W-1:0]   j,
  output logic [CELLS-1:0] mask
);
  always_comb begin
    mask = '0;
    if (int'(j) < LINES) mask = LINE_MASKS[j];
  end
endmodule

// File: rtl/bingo_mark_ctrl.sv
// Bingo board-state engine. Accepts a called number, scans the 5x5 map one
// cell per cycle, marks the first matching cell, then re-scores all 12 lines
// one per cycle and publishes mask/count/BCD/win together on the DONE edge.
// Ports: clk, rst (sync, active high), clear (new game), map (125-bit number
// map, read live), call_if (call handshake + done/hit/dup/miss), circle,
// line, line_count, display_nums, win.
module bingo_mark_ctrl
  import bingo_pkg::*;
#(
  parameter int WIN_THRESH = WIN_LINES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [CELLS*NUM_W-1:0] map,
  bingo_mark_ctrl_if.slave       call_if,
  output logic [CELLS-1:0]       circle,
  output logic [LINES-1:0]       line,
  output logic [3:0]             line_count,
  output logic [7:0]             display_nums,
  output logic                   win
);
  state_e           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [CELLS-1:0] circle_q, circle_d;
  logic [LINES-1:0] line_q, line_d, smask_q, smask_d;
  logic [3:0]       cnt_q, cnt_d, scnt_q, scnt_d;
  logic [7:0]       disp_q, disp_d;
  logic             win_q, win_d;
  logic             done_q, done_d, hit_q, hit_d, dup_q, dup_d, miss_q, miss_d;

  logic [CELLS-1:0] mask;
  logic [NUM_W-1:0] cell_val;
  logic             full;

  bingo_line_mask u_mask (.j(j_q), .mask(mask));

  assign cell_val = map[NUM_W*idx_q +: NUM_W];
  // Line j is complete when every cell on it is circled.
  assign full     = &(circle_q | ~mask);

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    idx_d    = idx_q;
    j_d      = j_q;
    circle_d = circle_q;
    line_d   = line_q;
    smask_d  = smask_q;
    cnt_d    = cnt_q;
    scnt_d   = scnt_q;
    disp_d   = disp_q;
    win_d    = win_q;
    done_d   = 1'b0;
    hit_d    = 1'b0;
    dup_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      IDLE: if (call_if.call_valid) begin
        num_d   = call_if.call_num;
        idx_d   = '0;
        state_d = SEARCH;
      end
      SEARCH: begin
        // Range check happens in the first SEARCH cycle so an illegal
        // number finishes with the same two-cycle latency as a cell-0 dup.
        if (num_q == '0 || num_q > MAX_NUM) begin
          miss_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (cell_val == num_q) begin
          if (circle_q[idx_q]) begin
            dup_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            circle_d[idx_q] = 1'b1;
            j_d     = '0;
            smask_d = '0;
            scnt_d  = '0;
            state_d = COUNT;
          end
        end else if (idx_q == LAST_IDX) begin
          miss_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      COUNT: begin
        smask_d[j_q] = full;
        scnt_d       = scnt_q + {3'b0, full};
        if (j_q == LAST_J) begin
          // Shadow results go live together so the display never shows
          // a half-scored board.
          line_d  = smask_d;
          cnt_d   = scnt_d;
          disp_d  = to_bcd(scnt_d);
          win_d   = win_q | (int'(scnt_d) >= WIN_THRESH);
          hit_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d  = IDLE;
      circle_d = '0;
      line_d   = '0;
      cnt_d    = '0;
      disp_d   = '0;
      win_d    = 1'b0;
      done_d   = 1'b0;
      hit_d    = 1'b0;
      dup_d    = 1'b0;
      miss_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      idx_q    <= '0;
      j_q      <= '0;
      circle_q <= '0;
      line_q   <= '0;
      smask_q  <= '0;
      cnt_q    <= '0;
      scnt_q   <= '0;
      disp_q   <= '0;
      win_q    <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      dup_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      j_q      <= j_d;
      circle_q <= circle_d;
      line_q   <= line_d;
      smask_q  <= smask_d;
      cnt_q    <= cnt_d;
      scnt_q   <= scnt_d;
      disp_q   <= disp_d;
      win_q    <= win_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
      dup_q    <= dup_d;
      miss_q   <= miss_d;
    end
  end

  // Ready is masked by rst so it reads 0 throughout reset and 1 as soon as
  // reset drops.
  assign call_if.call_ready = (state_q == IDLE) && !rst;
  assign call_if.done       = done_q;
  assign call_if.hit        = hit_q;
  assign call_if.dup        = dup_q;
  assign call_if.miss       = miss_q;
  assign circle             = circle_q;
  assign line               = line_q;
  assign line_count         = cnt_q;
  assign display_nums       = disp_q;
  assign win                = win_q;
endmodule

// File: tb/tb_bingo_mark_ctrl.sv
module tb_bingo_mark_ctrl;
  logic         clk = 1'b0;
  logic         rst, clear;
  logic [124:0] map;
  logic [24:0]  circle;
  logic [11:0]  line;
  logic [3:0]   line_count;
  logic [7:0]   display_nums;
  logic         win;

  bingo_mark_ctrl_if bif ();

  bingo_mark_ctrl dut (
    .clk(clk), .rst(rst), .clear(clear), .map(map), .call_if(bif),
    .circle(circle), .line(line), .line_count(line_count),
    .display_nums(display_nums), .win(win)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic        h, d, m;
    logic [24:0] circ;
    logic [11:0] ln;
    logic [3:0]  cnt;
    logic [7:0]  disp;
    logic        w;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          mapv[25];
  logic [24:0] m_circle;
  logic        m_win;

  // Reference scoring straight from board geometry.
  function automatic logic [11:0] m_lines(input logic [24:0] c);
    logic [11:0] l;
    logic r, cl, dg, ad;
    l = '0; dg = 1'b1; ad = 1'b1;
    for (int a = 0; a < 5; a++) begin
      r = 1'b1; cl = 1'b1;
      for (int b = 0; b < 5; b++) begin
        r  = r  & c[b + 5*a];
        cl = cl & c[a + 5*b];
      end
      l[a] = r; l[5+a] = cl;
      dg = dg & c[6*a];
      ad = ad & c[4 + 4*a];
    end
    l[10] = dg; l[11] = ad;
    return l;
  endfunction

  task automatic apply_map();
    for (int i = 0; i < 25; i++) map[i*5 +: 5] = 5'(mapv[i]);
  endtask

  task automatic do_call(input int num);
    exp_t e;
    int k, n, rlow, cnt;
    logic [11:0] ml;
    bit seen;
    n = 0;
    while (!bif.call_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (!bif.call_ready) begin
      errors++; $display("FAIL ready_wait: call_ready=%0b want 1", bif.call_ready);
      return;
    end
    bif.call_valid = 1'b1;
    bif.call_num   = 5'(num);
    e.h = 0; e.d = 0; e.m = 0;
    if (num < 1 || num > 25) begin e.m = 1; e.lat = 2; end
    else begin
      k = -1;
      for (int i = 0; i < 25; i++) if (k < 0 && mapv[i] == num) k = i;
      if (k < 0)                begin e.m = 1; e.lat = 26; end
      else if (m_circle[k])     begin e.d = 1; e.lat = 2 + k; end
      else begin e.h = 1; e.lat = 14 + k; m_circle[k] = 1'b1; end
    end
    ml  = m_lines(m_circle);
    cnt = $countones(ml);
    if (cnt >= 5) m_win = 1'b1;
    e.circ = m_circle; e.ln = ml; e.cnt = 4'(cnt);
    e.disp = {4'(cnt / 10), 4'(cnt % 10)}; e.w = m_win;
    sb.push_back(e);
    @(posedge clk); #1;
    bif.call_valid = 1'b0;
    bif.call_num   = 5'(num + 13);  // must be ignored after accept
    n = 1; seen = 0; rlow = 0;
    while (!seen && n < 40) begin
      if (!bif.call_ready) rlow++;
      if (bif.done) seen = 1;
      else begin @(posedge clk); #1; n++; end
    end
    e = sb.pop_front();
    checks++; if (!seen || n != e.lat) begin errors++; $display("FAIL latency num=%0d: got %0d (seen=%0b) want %0d", num, n, seen, e.lat); end
    checks++; if (rlow != e.lat) begin errors++; $display("FAIL ready_low num=%0d: got %0d want %0d", num, rlow, e.lat); end
    checks++; if ({bif.hit, bif.dup, bif.miss} !== {e.h, e.d, e.m}) begin errors++; $display("FAIL flags num=%0d: got %b want %b", num, {bif.hit, bif.dup, bif.miss}, {e.h, e.d, e.m}); end
    checks++; if (circle !== e.circ) begin errors++; $display("FAIL circle num=%0d: got %h want %h", num, circle, e.circ); end
    checks++; if (line !== e.ln) begin errors++; $display("FAIL line num=%0d: got %h want %h", num, line, e.ln); end
    checks++; if (line_count !== e.cnt) begin errors++; $display("FAIL line_count num=%0d: got %0d want %0d", num, line_count, e.cnt); end
    checks++; if (display_nums !== e.disp) begin errors++; $display("FAIL display num=%0d: got %h want %h", num, display_nums, e.disp); end
    checks++; if (win !== e.w) begin errors++; $display("FAIL win num=%0d: got %b want %b", num, win, e.w); end
    @(posedge clk); #1;
    checks++; if (bif.done !== 1'b0 || bif.call_ready !== 1'b1) begin errors++; $display("FAIL post_done num=%0d: done=%b ready=%b want 0/1", num, bif.done, bif.call_ready); end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    m_circle = '0; m_win = 1'b0;
    checks++; if ({circle, line, line_count, display_nums, win} !== '0) begin errors++; $display("FAIL clear_state: got %h/%h/%h/%h/%b want 0", circle, line, line_count, display_nums, win); end
    checks++; if (bif.call_ready !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b want 1", bif.call_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; bif.call_valid = 1'b0; bif.call_num = '0;
    for (int i = 0; i < 25; i++) mapv[i] = i + 1;
    apply_map();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bif.call_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bif.call_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bif.call_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", bif.call_ready); end
    checks++; if ({circle, line, line_count, win} !== '0) begin errors++; $display("FAIL reset_state: got %h/%h/%h/%b want 0", circle, line, line_count, win); end
    checks++; if (display_nums !== 8'h00) begin errors++; $display("FAIL reset_display: got %h want 00", display_nums); end
    checks++; if ({bif.done, bif.hit, bif.dup, bif.miss} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bif.done, bif.hit, bif.dup, bif.miss}); end
    m_circle = '0; m_win = 1'b0;
  endtask

  task automatic test_hit();
    do_call(7);
    checks++; if (circle !== 25'h40 || line !== 12'h000) begin errors++; $display("FAIL hit7: circle=%h line=%h want 0000040/000", circle, line); end
  endtask

  task automatic test_row();
    for (int v = 1; v <= 5; v++) do_call(v);
    checks++; if (line !== 12'h001 || line_count !== 4'd1 || display_nums !== 8'h01) begin errors++; $display("FAIL row0: line=%h cnt=%0d disp=%h want 001/1/01", line, line_count, display_nums); end
    do_call(5);
  endtask

  task automatic test_miss();
    do_call(0);
    do_call(26);
  endtask

  task automatic test_full();
    do_clear();
    for (int v = 1; v <= 25; v++) begin
      do_call(v);
      if (v == 20) begin checks++; if (win !== 1'b0) begin errors++; $display("FAIL win_early: got %b want 0", win); end end
      if (v == 21) begin checks++; if (win !== 1'b1) begin errors++; $display("FAIL win_rise: got %b want 1", win); end end
    end
    checks++; if (line !== 12'hFFF || line_count !== 4'd12 || display_nums !== 8'h12 || win !== 1'b1) begin errors++; $display("FAIL full: line=%h cnt=%0d disp=%h win=%b want FFF/12/12/1", line, line_count, display_nums, win); end
  endtask

  task automatic test_nomatch();
    do_clear();
    mapv[24] = 1;  // value 25 absent, value 1 appears at cells 0 and 24
    apply_map();
    do_call(25);
    do_call(1);
    do_call(1);
    mapv[24] = 25;
    apply_map();
  endtask

  task automatic test_clear_mid();
    bit early;
    do_clear();
    do_call(3);
    bif.call_valid = 1'b1; bif.call_num = 5'd7;
    @(posedge clk); #1;
    bif.call_valid = 1'b0;
    early = 0;
    repeat (9) begin @(posedge clk); #1; if (bif.done) early = 1; end
    checks++; if (circle !== 25'h44 || early) begin errors++; $display("FAIL mid_count: circle=%h early_done=%b want 0000044/0", circle, early); end
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (bif.done !== 1'b0 || {circle, line, line_count, win} !== '0) begin errors++; $display("FAIL abort: done=%b circle=%h line=%h win=%b want all 0", bif.done, circle, line, win); end
    checks++; if (bif.call_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bif.call_ready); end
    m_circle = '0; m_win = 1'b0;
    do_call(7);
  endtask

  initial begin
    test_reset();
    test_hit();
    test_row();
    test_miss();
    test_full();
    test_nomatch();
    test_clear_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
